// File: rtl/clock_pkg.sv
// clock_pkg: shared key-channel FSM states and default cycle constants.
//   btn_state_e      : RELEASED / HELD / REPEATING per-key state
//   *_CYC_DEF        : default timing in clk cycles (50 MHz)
package clock_pkg;
    typedef enum logic [1:0] {RELEASED, HELD, REPEATING} btn_state_e;
    localparam int DEBOUNCE_CYC_DEF = 1_000_000;
    localparam int HOLD_CYC_DEF     = 25_000_000;
    localparam int REPEAT_CYC_DEF   = 5_000_000;
endpackage

// File: rtl/btn_channel.sv
// btn_channel: one key path -- synchronizer, debouncer, press/hold/repeat FSM.
//   clk, reset_n : clock, async active-low reset
//   i_btn_n      : raw active-low key, asynchronous to clk
//   i_lock       : lockout from the top; parks the FSM in HELD with timers cleared
//   o_level      : debounced level, 1 = pressed
//   o_fire       : unregistered pulse request, registered (and gated) by the top
module btn_channel
    import clock_pkg::*;
#(
    parameter int   DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int   HOLD_CYC     = HOLD_CYC_DEF,
    parameter int   REPEAT_CYC   = REPEAT_CYC_DEF,
    parameter logic REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn_n,
    input  logic i_lock,
    output logic o_level,
    output logic o_fire
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam int REP_W  = $clog2(REPEAT_CYC + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYC - 1);

    logic [1:0]        r_sync;
    logic              r_level;
    logic [DB_W-1:0]   r_db_cnt;
    btn_state_e        r_state, w_state_nx;
    logic [HOLD_W-1:0] r_hold, w_hold_nx;
    logic [REP_W-1:0]  r_rep, w_rep_nx;
    logic              w_fire;

    // r_sync[1] is the synchronized key (active-low); r_level is the accepted pressed level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= 2'b11;
            r_level  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn_n};
            if ((~r_sync[1]) == r_level)
                r_db_cnt <= '0;
            else if (r_db_cnt == DB_LAST) begin
                r_level  <= ~r_sync[1];
                r_db_cnt <= '0;
            end else
                r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RELEASED;
            r_hold  <= '0;
            r_rep   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_hold  <= w_hold_nx;
            r_rep   <= w_rep_nx;
        end
    end

    // Timers default to 0, so any exit from a counting state clears them
    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = '0;
        w_rep_nx   = '0;
        w_fire     = 1'b0;
        case (r_state)
            RELEASED: begin
                if (r_level) begin
                    w_state_nx = HELD;
                    w_fire     = 1'b1;
                end
            end
            HELD: begin
                if (!r_level)
                    w_state_nx = RELEASED;
                else if (REPEAT_EN && !i_lock) begin
                    if (r_hold == HOLD_LAST) begin
                        w_state_nx = REPEATING;
                        w_fire     = 1'b1;
                    end else
                        w_hold_nx = r_hold + 1'b1;
                end
            end
            REPEATING: begin
                if (!r_level)
                    w_state_nx = RELEASED;
                else if (i_lock)
                    w_state_nx = HELD;
                else if (r_rep == REP_LAST)
                    w_fire = 1'b1;
                else
                    w_rep_nx = r_rep + 1'b1;
            end
            default: w_state_nx = RELEASED;
        endcase
    end

    assign o_level = r_level;
    assign o_fire  = w_fire;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions inc/dec/set keys into one-cycle requests for the clock core.
//   clk, reset_n        : clock, async active-low reset
//   i_btn_inc_n/dec_n   : raw active-low keys with auto-repeat
//   i_btn_set_n         : raw active-low key, one pulse per press
//   o_inc/dec/set_pulse : registered one-cycle requests
//   o_set_held          : registered debounced set level, 1 = pressed
module btn_conditioner
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int HOLD_CYC     = HOLD_CYC_DEF,
    parameter int REPEAT_CYC   = REPEAT_CYC_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn_inc_n,
    input  logic i_btn_dec_n,
    input  logic i_btn_set_n,
    output logic o_inc_pulse,
    output logic o_dec_pulse,
    output logic o_set_pulse,
    output logic o_set_held
);
    logic w_inc_level, w_dec_level, w_set_level;
    logic w_inc_fire, w_dec_fire, w_set_fire;
    logic w_lock;

    // Both directions pressed is ambiguous: silence both and restart hold timing
    assign w_lock = w_inc_level & w_dec_level;

    btn_channel #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1)) u_inc (
        .clk(clk), .reset_n(reset_n), .i_btn_n(i_btn_inc_n), .i_lock(w_lock),
        .o_level(w_inc_level), .o_fire(w_inc_fire)
    );

    btn_channel #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1)) u_dec (
        .clk(clk), .reset_n(reset_n), .i_btn_n(i_btn_dec_n), .i_lock(w_lock),
        .o_level(w_dec_level), .o_fire(w_dec_fire)
    );

    btn_channel #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0)) u_set (
        .clk(clk), .reset_n(reset_n), .i_btn_n(i_btn_set_n), .i_lock(1'b0),
        .o_level(w_set_level), .o_fire(w_set_fire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_inc_pulse <= 1'b0;
            o_dec_pulse <= 1'b0;
            o_set_pulse <= 1'b0;
            o_set_held  <= 1'b0;
        end else begin
            o_inc_pulse <= w_inc_fire & ~w_lock;
            o_dec_pulse <= w_dec_fire & ~w_lock;
            o_set_pulse <= w_set_fire;
            o_set_held  <= w_set_level;
        end
    end
endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1_000_000, cycles a synchronized input must hold a new level before it is accepted (20 ms at 50 MHz).
REQ-002 Parameter HOLD_CYC, default 25_000_000, cycles of continuous debounced press before auto-repeat starts (500 ms).
REQ-003 Parameter REPEAT_CYC, default 5_000_000, cycles between auto-repeat pulses (100 ms).
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 btn_inc_n  input  1  raw increment key, active-low, asynchronous to clk.
REQ-007 btn_dec_n  input  1  raw decrement key, active-low, asynchronous to clk.
REQ-008 btn_set_n  input  1  raw set-time key, active-low, asynchronous to clk.
REQ-009 inc_pulse  output  1  one-cycle increment request to the clock/calendar core.
REQ-010 dec_pulse  output  1  one-cycle decrement request.
REQ-011 set_pulse  output  1  one-cycle set-field-advance request.
REQ-012 set_held  output  1  debounced level of the set key, 1 = pressed.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-014 The debounced level SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYC consecutive cycles; any sample equal to the debounced level clears the stability counter.
REQ-015 Each channel SHALL run the FSM RELEASED -> HELD -> REPEATING, with HELD/REPEATING -> RELEASED on a debounced release.
REQ-016 On the debounced press edge, the FSM SHALL move RELEASED -> HELD and assert the channel pulse for exactly one cycle; total latency is 2 + DEBOUNCE_CYC cycles after the first clock edge that samples the key low.
REQ-017 In HELD, a hold counter SHALL count; at HOLD_CYC the FSM SHALL enter REPEATING and emit one pulse.
REQ-018 In REPEATING, the channel SHALL emit one pulse every REPEAT_CYC cycles while the key stays pressed.
REQ-019 Auto-repeat SHALL be enabled for the inc and dec channels only; the set channel stays in HELD until release and produces one pulse per press.
REQ-020 A debounced release SHALL produce no pulse, SHALL clear the hold and repeat counters, and SHALL return the FSM to RELEASED in the next cycle.
REQ-021 Mutual lockout: while inc and dec are both debounced-pressed, inc_pulse and dec_pulse SHALL both be 0, including repeat pulses; repeat timing resumes from HELD when one key is released.
REQ-022 Simultaneous debounced press edges on inc and dec in the same cycle SHALL produce no pulse on either.
REQ-023 The set channel SHALL be independent of inc and dec; set_pulse may coincide with inc_pulse or dec_pulse.
REQ-024 Counter widths SHALL be $clog2(max parameter + 1); counters SHALL saturate or clear and never wrap.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 On reset_n low, all synchronizer flops SHALL be set to 1 (released), debounced levels SHALL be released, FSMs SHALL go to RELEASED, counters SHALL go to 0, and inc_pulse, dec_pulse, set_pulse and set_held SHALL be 0, all asynchronously.
REQ-027 A key held through reset release SHALL be treated as a new press: one pulse after 2 + DEBOUNCE_CYC cycles.
REQ-028 Reset asserted mid-hold or mid-repeat SHALL abort the sequence with no further pulses until a new debounced press.

Structure
REQ-029 The FSM state enum (RELEASED, HELD, REPEATING) and the default cycle constants SHALL live in shared package clock_pkg.
REQ-030 One sub-module, btn_channel (sync, debounce, FSM, repeat enable parameter), SHALL be instantiated three times; the lockout logic stays in the top level.

Verification (DEBOUNCE_CYC=4, HOLD_CYC=10, REPEAT_CYC=3)
REQ-031 Press inc, hold 8 cycles, release -> exactly one inc_pulse, 6 cycles after the first low sample; no pulse on release.
REQ-032 Toggle dec low/high every 2 cycles for 20 cycles -> no dec_pulse.
REQ-033 Hold inc 30 cycles past debounce -> pulses at press, press+10, press+13, press+16, ... until release.
REQ-034 Hold set 30 cycles -> one set_pulse; set_held is 1 from the debounce point until the debounced release.
REQ-035 Press inc and dec together for 20 cycles -> no pulses; release dec -> inc resumes repeat 10 cycles later.
REQ-036 Assert reset_n low during inc repeat with the key held -> outputs 0 immediately; one inc_pulse 6 cycles after reset release.
